// File: rtl/reg_write_scoreboard.sv
// rtl/reg_write_scoreboard.sv - per-register in-flight writeback counters and RAW hazard detection
// Counts issued-but-not-written-back writes per architectural register; register 0 is never tracked.
module reg_write_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2,
  parameter int WB_BYPASS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_src1_id,
  input  logic [REG_ADDR_W-1:0] i_src2_id,
  input  logic                  i_is_imm,
  input  logic                  i_issue_valid,
  input  logic                  i_issue_wb_en,
  input  logic [REG_ADDR_W-1:0] i_issue_dest,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_dest,
  input  logic                  i_sb_clear,
  output logic                  o_hazard_detected,
  output logic                  o_pending_any,
  output logic                  o_overflow_err,
  output logic                  o_underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic             r_pending_any;
  logic             r_overflow_err;
  logic             r_underflow_err;

  logic [CNT_W-1:0] w_cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] w_pend;
  logic             w_inc;
  logic             w_dec;
  logic             w_ovf_hit;
  logic             w_unf_hit;
  logic             w_any_nxt;
  logic             w_hazard;

  assign w_dec = i_wb_valid && (i_wb_dest != '0);

  // A writeback landing this cycle on a count of 1 releases the reader early.
  always_comb begin
    w_pend = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_pend[r] = (r_cnt[r] != '0) &&
                  !((WB_BYPASS != 0) && w_dec &&
                    (i_wb_dest == REG_ADDR_W'(r)) && (r_cnt[r] == CNT_ONE));
    end
  end

  assign w_hazard = w_pend[i_src1_id] || (!i_is_imm && w_pend[i_src2_id]);

  // A stalled instruction does not leave ID, so its write must not be counted.
  assign w_inc = i_issue_valid && i_issue_wb_en && (i_issue_dest != '0) && !w_hazard;

  always_comb begin
    w_ovf_hit = 1'b0;
    w_unf_hit = 1'b0;
    w_any_nxt = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
    end
    if (i_sb_clear) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        w_cnt_nxt[r] = '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_inc && (i_issue_dest == REG_ADDR_W'(r)) &&
            !(w_dec && (i_wb_dest == REG_ADDR_W'(r)))) begin
          if (r_cnt[r] == CNT_MAX) begin
            w_ovf_hit = 1'b1;
          end else begin
            w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
          end
        end else if (w_dec && (i_wb_dest == REG_ADDR_W'(r)) &&
                     !(w_inc && (i_issue_dest == REG_ADDR_W'(r)))) begin
          if (r_cnt[r] == '0) begin
            w_unf_hit = 1'b1;
          end else begin
            w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
          end
        end
      end
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      w_any_nxt = w_any_nxt || (w_cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
      r_pending_any   <= 1'b0;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      r_pending_any   <= w_any_nxt;
      r_overflow_err  <= r_overflow_err || w_ovf_hit;
      r_underflow_err <= r_underflow_err || w_unf_hit;
    end
  end

  assign o_hazard_detected = w_hazard;
  assign o_pending_any     = r_pending_any;
  assign o_overflow_err    = r_overflow_err;
  assign o_underflow_err   = r_underflow_err;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// tb/tb_reg_write_scoreboard.sv - scoreboard-driven bench for reg_write_scoreboard
// Expected hazard/status values are queued when a cycle is driven and popped when sampled.
module tb_reg_write_scoreboard;

  localparam int NR   = 32;
  localparam int AW   = 5;
  localparam int MAXC = 3;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] src1, src2, idest, wdest;
  logic          is_imm, iv, iwe, wv, clr;
  logic          haz, pend_any, ovf, unf;

  reg_write_scoreboard #(.NUM_REGS(NR), .REG_ADDR_W(AW), .CNT_W(2), .WB_BYPASS(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_src1_id(src1), .i_src2_id(src2), .i_is_imm(is_imm),
    .i_issue_valid(iv), .i_issue_wb_en(iwe), .i_issue_dest(idest),
    .i_wb_valid(wv), .i_wb_dest(wdest), .i_sb_clear(clr),
    .o_hazard_detected(haz), .o_pending_any(pend_any),
    .o_overflow_err(ovf), .o_underflow_err(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int         m_cnt [NR];
  bit         m_ovf, m_unf, m_pend;
  logic       q_haz [$];
  logic [2:0] q_stat [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pend_reg(input logic [AW-1:0] r, input bit dec, input logic [AW-1:0] wd);
    return (r != 0) && (m_cnt[r] != 0) && !(dec && (wd == r) && (m_cnt[r] == 1));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    m_ovf = 0; m_unf = 0; m_pend = 0;
  endtask

  task automatic step(input string tag, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                      input logic imm, input logic v, input logic we, input logic [AW-1:0] id,
                      input logic w, input logic [AW-1:0] wd, input logic c);
    bit dec, inc, h;
    int nxt [NR];
    @(negedge clk);
    src1 = s1; src2 = s2; is_imm = imm; iv = v; iwe = we; idest = id;
    wv = w; wdest = wd; clr = c;
    dec = w && (wd != 0);
    h   = m_pend_reg(s1, dec, wd) || (!imm && m_pend_reg(s2, dec, wd));
    q_haz.push_back(h);
    inc = v && we && (id != 0) && !h;
    for (int r = 0; r < NR; r++) nxt[r] = c ? 0 : m_cnt[r];
    if (!c && !(inc && dec && id == wd)) begin
      if (inc) begin
        if (m_cnt[id] == MAXC) m_ovf = 1; else nxt[id] = m_cnt[id] + 1;
      end
      if (dec) begin
        if (m_cnt[wd] == 0) m_unf = 1; else nxt[wd] = m_cnt[wd] - 1;
      end
    end
    m_pend = 0;
    for (int r = 0; r < NR; r++) begin
      m_cnt[r] = nxt[r];
      if (nxt[r] != 0) m_pend = 1;
    end
    q_stat.push_back({m_pend, m_ovf, m_unf});
    #1;
    check_eq({tag, "/hazard"}, haz, q_haz.pop_front());
    @(posedge clk);
    #1;
    check_eq({tag, "/status"}, {pend_any, ovf, unf}, q_stat.pop_front());
  endtask

  task automatic issue(input string tag, input logic [AW-1:0] d);
    step(tag, 0, 0, 1, 1, 1, d, 0, 0, 0);
  endtask

  task automatic wb(input string tag, input logic [AW-1:0] s1, input logic [AW-1:0] d);
    step(tag, s1, 0, 1, 0, 0, 0, 1, d, 0);
  endtask

  task automatic look(input string tag, input logic [AW-1:0] s1);
    step(tag, s1, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; src1 = 0; src2 = 0; is_imm = 0; iv = 0; iwe = 0; idest = 0;
    wv = 0; wdest = 0; clr = 0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      src1 = AW'($urandom); src2 = AW'($urandom); is_imm = 1'($urandom);
      iv = 1'($urandom); iwe = 1'($urandom); idest = AW'($urandom);
      wv = 1'($urandom); wdest = AW'($urandom); clr = 1'($urandom);
      #1;
      check_eq("reset/outputs", {haz, pend_any, ovf, unf}, 4'b0000);
    end
    @(negedge clk);
    iv = 0; wv = 0; clr = 0;
    rst_n = 1;

    issue("raw_issue", 5);
    look("raw_stall", 5);
    check_eq("raw_stall_direct", haz, 1'b1);
    wb("raw_wb_bypass", 5, 5);
    look("raw_after", 5);

    issue("imm_issue", 7);
    step("imm_masked", 3, 7, 1, 0, 0, 0, 0, 0, 0);
    step("imm_used", 3, 7, 0, 0, 0, 0, 0, 0, 0);
    check_eq("imm_used_direct", haz, 1'b1);
    wb("imm_wb", 0, 7);

    issue("dbl_issue1", 9);
    issue("dbl_issue2", 9);
    wb("dbl_wb1", 9, 9);
    look("dbl_mid", 9);
    wb("dbl_wb2", 9, 9);
    look("dbl_done", 9);

    issue("same_issue", 4);
    step("same_inc_dec", 0, 0, 1, 1, 1, 4, 1, 4, 0);
    look("same_held", 4);
    step("zero_reg", 0, 0, 1, 1, 1, 0, 1, 0, 0);
    step("no_wb_en", 0, 0, 1, 1, 0, 3, 0, 0, 0);
    look("no_wb_en_chk", 3);
    wb("same_wb", 0, 4);

    issue("gate_issue", 10);
    step("gated", 10, 0, 1, 1, 1, 11, 0, 0, 0);
    look("gated_chk", 11);
    wb("gate_wb", 0, 10);

    for (int i = 0; i < 4; i++) issue("ovf_issue", 2);
    check_eq("ovf_direct", ovf, 1'b1);
    wb("ovf_wb1", 2, 2);
    wb("ovf_wb2", 2, 2);
    wb("ovf_wb3", 2, 2);
    look("ovf_drained", 2);
    check_eq("unf_still_clear", unf, 1'b0);

    wb("unf_wb_idle", 0, 6);
    check_eq("unf_direct", unf, 1'b1);

    issue("clr_issue12", 12);
    issue("clr_issue13", 13);
    step("clr", 12, 13, 0, 0, 0, 0, 0, 0, 1);
    check_eq("clr_pending_direct", pend_any, 1'b0);
    check_eq("clr_errors_direct", {ovf, unf}, 2'b11);
    look("clr_after", 13);

    rst_n = 0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 300; i++) begin
      logic c;
      c = ($urandom_range(0, 39) == 0);
      step("rand", AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'($urandom),
           !c && ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) != 0),
           AW'($urandom_range(0, 7)), !c && ($urandom_range(0, 2) != 0),
           AW'($urandom_range(0, 7)), c);
    end

    issue("mid_issue", 8);
    @(negedge clk);
    src1 = 8; is_imm = 1; iv = 0; wv = 0; clr = 0;
    rst_n = 0;
    #1;
    check_eq("mid_reset/outputs", {haz, pend_any, ovf, unf}, 4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    look("post_reset", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
